id_ex_stage: RTL

- ID/EX pipeline register plus operand-selection front end for the ALU.
- Latches decoded instruction state from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operands `alu_a`/`alu_b` and `aluctr`, and forwards the control bits to EX/MEM.
- Detects load-use hazards and inserts bubbles.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 35 +++
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU op, register and forward-select definitions
package mips_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_ADDU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_MOVN = 3'b111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - per-operand forward source selection
module fwd_unit
    import mips_pkg::*;
#(
    parameter int NREG_BITS = 5
) (
    input  logic [NREG_BITS-1:0] src_reg_i,
    input  logic                 exm_regwre_i,
    input  logic                 exm_wrctr_i,
    input  logic [NREG_BITS-1:0] exm_wreg_i,
    input  logic                 mwb_regwre_i,
    input  logic [NREG_BITS-1:0] mwb_wreg_i,
    output fwd_sel_e             sel_o
);

    localparam logic [NREG_BITS-1:0] ZERO = NREG_BITS'(REG_ZERO);

    logic exm_hit;
    logic mwb_hit;

    // A wrctr-suppressed EX/MEM result (overflow, movn not taken) is never forwarded.
    assign exm_hit = exm_regwre_i && exm_wrctr_i && (exm_wreg_i != ZERO) && (exm_wreg_i == src_reg_i);
    assign mwb_hit = mwb_regwre_i && (mwb_wreg_i != ZERO) && (mwb_wreg_i == src_reg_i);

    // EX/MEM holds the younger write, so it wins over MEM/WB.
    always_comb begin
        sel_o = FWD_RF;
        if (exm_hit) begin
            sel_o = FWD_EXM;
        end else if (mwb_hit) begin
            sel_o = FWD_MWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register, ALU operand selection and hazard stall (option macro: ID_EX_FORWARD_EN)
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int NREG_BITS = 5,
    parameter int DW        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [2:0]           id_aluctr,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic [DW-1:0]        id_rs_val,
    input  logic [DW-1:0]        id_rt_val,
    input  logic [DW-1:0]        id_imm,
    input  logic [4:0]           id_shamt,
    input  logic                 id_alusrc,
    input  logic                 id_shsrc,
    input  logic                 id_regdst,
    input  logic                 id_regwre,
    input  logic                 id_memread,
    input  logic                 id_memwrite,
    input  logic                 id_memtoreg,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 exm_regwre,
    input  logic                 exm_wrctr,
    input  logic [NREG_BITS-1:0] exm_wreg,
    input  logic [DW-1:0]        exm_res,
    input  logic                 mwb_regwre,
    input  logic [NREG_BITS-1:0] mwb_wreg,
    input  logic [DW-1:0]        mwb_data,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [2:0]           aluctr,
    output logic [DW-1:0]        ex_store_data,
    output logic [NREG_BITS-1:0] ex_wreg,
    output logic                 ex_valid,
    output logic                 ex_regwre,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    output logic                 ex_memtoreg,
    output logic                 stall
);

    localparam logic [NREG_BITS-1:0] ZERO = NREG_BITS'(REG_ZERO);

    typedef struct packed {
        logic                 valid;
        logic                 regwre;
        logic                 memread;
        logic                 memwrite;
        logic                 memtoreg;
        logic [2:0]           aluctr;
        logic [NREG_BITS-1:0] wreg;
        logic [NREG_BITS-1:0] rs;
        logic [NREG_BITS-1:0] rt;
        logic [DW-1:0]        rs_val;
        logic [DW-1:0]        rt_val;
        logic [DW-1:0]        imm;
        logic [4:0]           shamt;
        logic                 alusrc;
        logic                 shsrc;
    } idex_t;

    idex_t         idex_q;
    idex_t         idex_d;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    logic ex_match;
    logic load_use;
    logic raw_hazard;

    // ID reads the register that the instruction now in EX will write.
    assign ex_match = (idex_q.wreg != ZERO) &&
                      ((id_uses_rs && (id_rs == idex_q.wreg)) ||
                       (id_uses_rt && (id_rt == idex_q.wreg)));
    assign load_use = idex_q.valid && idex_q.memread && ex_match;

`ifdef ID_EX_FORWARD_EN
    assign raw_hazard = 1'b0;
`else
    logic exm_match;

    // Without forwarding, any pending write in EX or EX/MEM must drain first;
    // MEM/WB is covered by register-file write-through.
    assign exm_match = exm_regwre && (exm_wreg != ZERO) &&
                       ((id_uses_rs && (id_rs == exm_wreg)) ||
                        (id_uses_rt && (id_rt == exm_wreg)));
    assign raw_hazard = (idex_q.valid && idex_q.regwre && ex_match) || exm_match;
`endif

    // Flush wins so IF can redirect without waiting on a stall.
    assign stall = !flush && (load_use || raw_hazard);

    // Next state: hold freezes, flush or stall inserts a bubble, otherwise capture ID.
    always_comb begin
        idex_d = idex_q;
        if (!hold) begin
            if (flush || stall) begin
                idex_d = '0;
            end else begin
                idex_d.valid    = id_valid;
                idex_d.regwre   = id_regwre   && id_valid;
                idex_d.memread  = id_memread  && id_valid;
                idex_d.memwrite = id_memwrite && id_valid;
                idex_d.memtoreg = id_memtoreg && id_valid;
                idex_d.aluctr   = id_aluctr;
                idex_d.wreg     = id_regdst ? id_rd : id_rt;
                idex_d.rs       = id_rs;
                idex_d.rt       = id_rt;
                idex_d.rs_val   = id_rs_val;
                idex_d.rt_val   = id_rt_val;
                idex_d.imm      = id_imm;
                idex_d.shamt    = id_shamt;
                idex_d.alusrc   = id_alusrc;
                idex_d.shsrc    = id_shsrc;
            end
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    fwd_sel_e rs_sel;
    fwd_sel_e rt_sel;

    fwd_unit #(.NREG_BITS(NREG_BITS)) u_fwd_rs (
        .src_reg_i    (idex_q.rs),
        .exm_regwre_i (exm_regwre),
        .exm_wrctr_i  (exm_wrctr),
        .exm_wreg_i   (exm_wreg),
        .mwb_regwre_i (mwb_regwre),
        .mwb_wreg_i   (mwb_wreg),
        .sel_o        (rs_sel)
    );

    fwd_unit #(.NREG_BITS(NREG_BITS)) u_fwd_rt (
        .src_reg_i    (idex_q.rt),
        .exm_regwre_i (exm_regwre),
        .exm_wrctr_i  (exm_wrctr),
        .exm_wreg_i   (exm_wreg),
        .mwb_regwre_i (mwb_regwre),
        .mwb_wreg_i   (mwb_wreg),
        .sel_o        (rt_sel)
    );

    assign fwd_rs = (rs_sel == FWD_EXM) ? exm_res :
                    (rs_sel == FWD_MWB) ? mwb_data : idex_q.rs_val;
    assign fwd_rt = (rt_sel == FWD_EXM) ? exm_res :
                    (rt_sel == FWD_MWB) ? mwb_data : idex_q.rt_val;
`else
    logic unused_fwd;

    assign fwd_rs     = idex_q.rs_val;
    assign fwd_rt     = idex_q.rt_val;
    assign unused_fwd = &{1'b0, exm_wrctr, exm_res, mwb_regwre, mwb_wreg, mwb_data,
                          idex_q.rs, idex_q.rt};
`endif

    // movn relies on alu_b carrying the forwarded rt for its zero test.
    assign alu_a         = idex_q.shsrc  ? {{(DW-5){1'b0}}, idex_q.shamt} : fwd_rs;
    assign alu_b         = idex_q.alusrc ? idex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;

    assign aluctr      = idex_q.aluctr;
    assign ex_wreg     = idex_q.wreg;
    assign ex_valid    = idex_q.valid;
    assign ex_regwre   = idex_q.regwre;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_memtoreg = idex_q.memtoreg;

endmodule
